// File: rtl/csa_resolver.sv
// Final carry-propagate stage: resolves a carry-save (sum, cout<<1) pair into binary, CHUNK bits per cycle.
// Optional CSA_RESOLVE_CARRY_EN adds the 2-bit out_carry port with the overflow bits of the exact sum.
module csa_resolver #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result
`ifdef CSA_RESOLVE_CARRY_EN
    ,
    output logic [1:0]       out_carry
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
`ifdef CSA_RESOLVE_CARRY_EN
    localparam int OPW    = WIDTH + 2;
`else
    // Without the overflow port the top two operand bits feed nothing.
    localparam int OPW    = WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            state_q, state_d;
    logic [OPW-1:0]    a_q, a_d, b_q, b_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [CHUNK-1:0]  a_ch, b_ch;
    logic [CHUNK:0]    chunk_sum;
    logic              last;
`ifdef CSA_RESOLVE_CARRY_EN
    logic [1:0]        ovf_q, ovf_d;
`endif

    assign last = (idx_q == IDXW'(NCHUNK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
`ifdef CSA_RESOLVE_CARRY_EN
            ovf_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            res_q   <= res_d;
`ifdef CSA_RESOLVE_CARRY_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ADD;
            ADD:     if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Chunk select by loop so every part-select has a constant base.
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_ch = a_q[k*CHUNK +: CHUNK];
                b_ch = b_q[k*CHUNK +: CHUNK];
            end
        end
        chunk_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        res_d   = res_q;
`ifdef CSA_RESOLVE_CARRY_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = OPW'(in_sum);
                    b_d     = OPW'({in_cout, 1'b0});
                    idx_d   = '0;
                    carry_d = 1'b0;
                end
            end
            ADD: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (idx_q == IDXW'(k)) res_d[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                end
                carry_d = chunk_sum[CHUNK];
                idx_d   = last ? '0 : idx_q + 1'b1;
`ifdef CSA_RESOLVE_CARRY_EN
                if (last) begin
                    ovf_d   = a_q[OPW-1:WIDTH] + b_q[OPW-1:WIDTH] + {1'b0, chunk_sum[CHUNK]};
                    carry_d = 1'b0;
                end
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        out_result = res_q;
`ifdef CSA_RESOLVE_CARRY_EN
        out_carry  = ovf_q;
`endif
    end

endmodule
